// File: rtl/lz77_stream_decoder.sv
// lz77_stream_decoder: LZ77 token stream to symbol stream decoder with a shift-register history.
//   clk, reset (async, active-low)
//   in_valid/in_ready/code_pos/code_len/chardata : token input (copy offset, copy length, literal)
//   out_valid/out_ready/out_char                 : decoded symbol output
//   finish (sticky, TERM_CHAR literal delivered), pos_err (sticky, out-of-range copy offset)
//   char_count                                   : symbols delivered since reset, saturating
module lz77_stream_decoder #(
   parameter int DEPTH = 30,
   parameter int CHAR_W = 8,
   parameter int POS_W = 5,
   parameter int LEN_W = 5,
   parameter logic [CHAR_W-1:0] TERM_CHAR = 8'h24,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [POS_W-1:0]  code_pos,
   input  logic [LEN_W-1:0]  code_len,
   input  logic [CHAR_W-1:0] chardata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CHAR_W-1:0] out_char,
   output logic              finish,
   output logic              pos_err,
   output logic [CNT_W-1:0]  char_count
);
   typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;
   state_t state;
   logic [CHAR_W-1:0] hist [DEPTH];
   logic [POS_W-1:0] pos_q;
   logic [LEN_W-1:0] rem_q;
   logic [CHAR_W-1:0] chr_q;
   logic bad_pos, fire;
   // in_ready is gated by reset so it reads 0 while reset is held low
   assign in_ready = reset && state == IDLE;
   assign out_valid = state == COPY || state == LIT;
   // copies read the live history, so overlapping copies see symbols just emitted
   assign out_char = state == COPY ? hist[pos_q] : chr_q;
   assign fire = out_valid && out_ready;
   assign bad_pos = code_len != '0 && 32'(code_pos) >= DEPTH;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
         pos_q <= '0;
         rem_q <= '0;
         chr_q <= '0;
         finish <= 1'b0;
         pos_err <= 1'b0;
         char_count <= '0;
      end else begin
         if (fire) begin
            hist[0] <= out_char;
            for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
            if (char_count != '1) char_count <= char_count + CNT_W'(1);
         end
         case (state)
            IDLE:
               if (in_valid) begin
                  pos_q <= code_pos;
                  chr_q <= chardata;
                  rem_q <= bad_pos ? '0 : code_len;
                  pos_err <= pos_err | bad_pos;
                  state <= (code_len != '0 && !bad_pos) ? COPY : LIT;
               end
            COPY:
               if (out_ready) begin
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) state <= LIT;
               end
            LIT:
               if (out_ready) begin
                  if (chr_q == TERM_CHAR) finish <= 1'b1;
                  state <= chr_q == TERM_CHAR ? DONE : IDLE;
               end
            default: state <= DONE;
         endcase
      end
endmodule

// File: doc/lz77_stream_decoder.md
LZ77_STREAM_DECODER -- requirements
Module: lz77_stream_decoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 30, meaning number of history-buffer entries.
REQ-002 The block SHALL have parameter CHAR_W, default 8, meaning symbol width.
REQ-003 The block SHALL have parameter POS_W, default 5, meaning code_pos width; DEPTH <= 2^POS_W.
REQ-004 The block SHALL have parameter LEN_W, default 5, meaning code_len width.
REQ-005 The block SHALL have parameter TERM_CHAR, default 8'h24, meaning end-of-stream literal.
REQ-006 The block SHALL have parameter CNT_W, default 16, meaning width of char_count.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 in_valid  input  1  token (code_pos, code_len, chardata) present.
REQ-010 in_ready  output  1  block accepts a token this cycle.
REQ-011 code_pos  input  POS_W  copy offset; 0 = most recently emitted symbol.
REQ-012 code_len  input  LEN_W  number of copied symbols before the literal.
REQ-013 chardata  input  CHAR_W  literal symbol closing the token.
REQ-014 out_valid  output  1  out_char holds a decoded symbol.
REQ-015 out_ready  input  1  downstream accepts out_char this cycle.
REQ-016 out_char  output  CHAR_W  decoded symbol.
REQ-017 finish  output  1  TERM_CHAR literal has been delivered; sticky.
REQ-018 pos_err  output  1  sticky flag: a token arrived with code_len>0 and code_pos>=DEPTH.
REQ-019 char_count  output  CNT_W  symbols delivered since reset; saturates at all-ones.

Function
REQ-020 The block SHALL hold history buf[0..DEPTH-1] in a shift register, buf[0] being the newest symbol.
REQ-021 The FSM SHALL have states IDLE, COPY, LIT and DONE.
REQ-022 in_ready SHALL be 1 only in IDLE; a token is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-023 On acceptance the block SHALL latch pos, len and char; next state is COPY if len>0, else LIT.
REQ-024 In COPY, out_valid SHALL be 1 and out_char SHALL equal buf[pos_latched] combinationally.
REQ-025 In LIT, out_valid SHALL be 1 and out_char SHALL equal the latched char.
REQ-026 Each out handshake (out_valid and out_ready both 1) SHALL shift out_char into buf[0], move buf[i] to buf[i+1], discard buf[DEPTH-1], and increment char_count.
REQ-027 Overlapping copies (len > pos+1) SHALL read the freshly shifted buffer, reproducing run-length repetition.
REQ-028 In COPY, the remaining count SHALL decrement per handshake; on the handshake with remaining==1 the FSM SHALL go to LIT.
REQ-029 On a LIT handshake, the FSM SHALL go to DONE and set finish if char==TERM_CHAR, else go to IDLE.
REQ-030 With out_ready low, out_char, buf and state SHALL hold (no symbol loss or duplication).
REQ-031 If code_len>0 and code_pos>=DEPTH, the block SHALL set pos_err and treat the token as code_len=0 (literal only).
REQ-032 In DONE, in_ready and out_valid SHALL be 0 until reset; new inputs SHALL be ignored.
REQ-033 code_len=2^LEN_W-1 SHALL emit exactly that many copies plus one literal.
REQ-034 Throughput SHALL be len+1 symbols per len+2 cycles with out_ready held high (one accept cycle per token).

Reset
REQ-035 Asserting reset (low) SHALL immediately clear state to IDLE, all buf entries to 0, finish=0, pos_err=0, char_count=0, out_valid=0, in_ready=0 while reset is low, and clear the latched token.
REQ-036 Reset asserted mid-COPY SHALL abort the token without emitting further symbols; after release the block SHALL be in IDLE with in_ready=1.
REQ-037 A copy from a never-written entry SHALL yield 0.

Verification
REQ-038 Literals 'a','b' (len=0), then token pos=1, len=3, char='$' with out_ready=1 -> out_char "a b a b a $", finish=1 after the '$' handshake, char_count=6.
REQ-039 Literal 'x', then pos=0, len=31, char='y' -> 32 consecutive 'x' followed by 'y'; in_ready low throughout the copy.
REQ-040 Same stream with out_ready toggled randomly -> identical output sequence; out_char stable while out_valid=1 and out_ready=0.
REQ-041 Token pos=30, len=2, char='q' at DEPTH=30 -> pos_err=1, only 'q' emitted, char_count +1.
REQ-042 Reset pulsed low during the COPY of a len=10 token -> outputs cleared immediately; after release in_ready=1, buf reads 0, char_count=0.
REQ-043 After finish, drive in_valid=1 with further tokens -> no handshake, out_valid=0, char_count unchanged; repeat at DEPTH=8, POS_W=3.
